pattern_det_sched: RTL

Round-robin scheduler that shares one bit-serial overlapping pattern detector (Mealy, ports d/valid in, single-cycle `pattern` hit out) among NUM_CH requester streams. It grants the detector to one channel per burst and clears the detector's history between grants, so overlap never spans two channels. It tags each hit with its source channel and keeps a saturating per-channel hit counter readable by software. It sits between the stream sources and the single detector instance.

---
 rtl/pattern_det_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pattern_det_sched.sv
// Round-robin scheduler that shares one bit-serial overlapping pattern detector
// among NUM_CH requester streams. Every grant opens with a one-cycle detector
// clear, so overlapping matches never span two channels. Hits are registered,
// tagged with their source channel and tallied in saturating per-channel counters.
module pattern_det_sched #(
   parameter int NUM_CH    = 4,
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 8,
   localparam int IW       = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req_i,
   input  logic [NUM_CH-1:0] d_i,
   input  logic [NUM_CH-1:0] valid_i,
   output logic [NUM_CH-1:0] ready_o,
   output logic              det_d_o,
   output logic              det_valid_o,
   output logic              det_clr_o,
   input  logic              det_hit_i,
   output logic              hit_o,
   output logic [IW-1:0]     hit_ch_o,
   input  logic [IW-1:0]     cnt_sel_i,
   output logic [CNT_W-1:0]  cnt_o,
   input  logic              cnt_clr_i
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLR   = 2'd1;
   localparam logic [1:0] GRANT = 2'd2;

   localparam int               BCW       = 8;
   localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [1:0]       state;
   logic [IW-1:0]    g;
   logic [IW-1:0]    last_grant;
   logic [BCW-1:0]   beat_cnt;
   logic [IW-1:0]    pick;
   logic             pick_vld;
   logic [IW-1:0]    cand;
   logic             beat;
   logic             hit_s;
   logic [CNT_W-1:0] cnt_q [NUM_CH];

   // Round-robin pick: first requester after last_grant, wrapping (IW-bit add wraps for free).
   // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pick     = last_grant;
      pick_vld = 1'b0;
      cand     = last_grant;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = last_grant + IW'(i);
         if (!pick_vld && req_i[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // A beat is an accepted bit from the granted channel; everything downstream keys off it.
   assign beat        = (state == GRANT) && valid_i[g];
   assign det_valid_o = beat;
   assign det_d_o     = beat & d_i[g];
   assign det_clr_o   = (state == CLR);
   assign hit_s       = beat & det_hit_i;
   assign cnt_o       = cnt_q[cnt_sel_i];

   // Ready is one-hot on the granted channel while in GRANT, zero otherwise.
   always_comb begin
      ready_o = '0;
      if (state == GRANT) ready_o[g] = 1'b1;
   end

   // Grant FSM: IDLE picks, CLR wipes detector history, GRANT streams until burst end or release.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         g          <= '0;
         last_grant <= IW'(NUM_CH - 1);
         beat_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  g     <= pick;
                  state <= CLR;
               end
            end
            CLR: begin
               beat_cnt <= '0;
               state    <= GRANT;
            end
            GRANT: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) begin
                     state      <= IDLE;
                     last_grant <= g;
                  end
               end else if (!req_i[g]) begin
                  state      <= IDLE;
                  last_grant <= g;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered hit pulse; the channel tag holds its last value between hits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_o    <= 1'b0;
         hit_ch_o <= '0;
      end else begin
         hit_o <= hit_s;
         if (hit_s) hit_ch_o <= g;
      end
   end

   // Saturating per-channel hit counters; a software clear beats a same-cycle hit on that channel.
   // NOTE: this counter array is reset on purpose because software reads it as a tally; plain data storage would be left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (cnt_clr_i && (cnt_sel_i == IW'(ch))) begin
               cnt_q[ch] <= '0;
            end else if (hit_s && (g == IW'(ch)) && (cnt_q[ch] != CNT_MAX)) begin
               cnt_q[ch] <= cnt_q[ch] + 1'b1;
            end
         end
      end
   end

endmodule
